pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator, the successor to the single-channel 50-step generator and button-driven duty logic. It has CH independent channels sharing one programmable timebase, in edge-aligned or center-aligned mode. Duty and period changes go through a pending/active shadow pair, so they take effect only at a period boundary and the outputs never glitch. It sits between the duty-control front end (buttons/host) and the output pins; `duty_q` feeds the seven-segment display path.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_timebase.sv | 64 ++++++
 rtl/pwm_multi.sv | 126 ++++++++++++
 tb/tb_pwm_multi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
// Duty opcodes, output modes and the center-mode counting direction.
package pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_SET  = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } duty_op_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } phase_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: counter, up/down phase, period boundary and tick.
// The phase register is the only state machine; cnt/phase are held at 0/UP while disabled.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clkin,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] per_act,
    input  mode_t        mode_act,
    output logic [W-1:0] cnt,
    output logic         boundary,
    output logic         period_tick
);

    phase_t       phase;
    phase_t       phase_next;
    logic [W-1:0] cnt_next;
    logic         at_top;

    always_ff @(posedge clkin) begin
        if (reset) begin
            cnt         <= '0;
            phase       <= UP;
            period_tick <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            phase       <= phase_next;
            period_tick <= boundary;
        end
    end

    always_comb begin
        at_top     = (cnt == per_act - 1'b1);
        boundary   = 1'b0;
        cnt_next   = cnt;
        phase_next = phase;
        if (!enable) begin
            cnt_next   = '0;
            phase_next = UP;
        end else if (mode_act == MODE_EDGE) begin
            boundary   = at_top;
            cnt_next   = at_top ? '0 : cnt + 1'b1;
            phase_next = UP;
        end else if (phase == UP) begin
            // the top count is held for one extra clock while turning around
            if (at_top) begin
                phase_next = DOWN;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end else begin
            if (cnt == '0) begin
                boundary   = 1'b1;
                phase_next = UP;
            end else begin
                cnt_next = cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// CH-channel PWM generator with pending/active shadow registers for period, mode and duties.
// Active values change only at a period boundary (or every clock while disabled).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH         = 4,
    parameter int W          = 8,
    parameter int PERIOD_DEF = 50,
    localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clkin,
    input  logic            reset,
    input  logic            enable,
    input  logic            mode_in,
    input  logic            per_we,
    input  logic [W-1:0]    period_data,
    input  logic [1:0]      duty_op,
    input  logic [CHW-1:0]  duty_ch,
    input  logic [W-1:0]    duty_data,
    output logic [CH-1:0]   pwm_out,
    output logic            period_tick,
    output logic [CH*W-1:0] duty_q
);

    localparam logic [W-1:0] PER_RESET = (PERIOD_DEF < 2) ? W'(1) : W'(PERIOD_DEF);

    function automatic logic [W-1:0] coerce_period(input logic [W-1:0] p);
        return (p <= W'(1)) ? W'(1) : p;
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? '0 : a - b;
    endfunction

    logic [W-1:0] per_pend;
    logic [W-1:0] per_act;
    logic [W-1:0] per_pend_next;
    mode_t        mode_pend;
    mode_t        mode_act;
    logic [W-1:0] duty_pend      [CH];
    logic [W-1:0] duty_act       [CH];
    logic [W-1:0] duty_pend_next [CH];
    logic [CH-1:0] pwm_next;
    duty_op_t     op;
    logic         ch_ok;
    logic         load;
    logic         boundary;
    logic [W-1:0] cnt;

    assign op    = duty_op_t'(duty_op);
    assign ch_ok = (32'(duty_ch) < 32'(CH));
    assign load  = boundary | ~enable;

    pwm_timebase #(.W(W)) u_timebase (
        .clkin       (clkin),
        .reset       (reset),
        .enable      (enable),
        .per_act     (per_act),
        .mode_act    (mode_act),
        .cnt         (cnt),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    always_comb begin
        per_pend_next  = per_we ? coerce_period(period_data) : per_pend;
        duty_pend_next = duty_pend;
        if (ch_ok) begin
            case (op)
                OP_SET:  duty_pend_next[duty_ch] = duty_data;
                OP_INC:  duty_pend_next[duty_ch] = sat_add(duty_pend[duty_ch], duty_data);
                OP_DEC:  duty_pend_next[duty_ch] = sat_sub(duty_pend[duty_ch], duty_data);
                default: duty_pend_next[duty_ch] = duty_pend[duty_ch];
            endcase
        end
    end

    // A duty op issued in the boundary clock goes straight into the active set.
    always_ff @(posedge clkin) begin
        if (reset) begin
            per_pend  <= PER_RESET;
            per_act   <= PER_RESET;
            mode_pend <= MODE_EDGE;
            mode_act  <= MODE_EDGE;
            for (int c = 0; c < CH; c++) begin
                duty_pend[c] <= '0;
                duty_act[c]  <= '0;
            end
        end else begin
            per_pend  <= per_pend_next;
            mode_pend <= mode_t'(mode_in);
            duty_pend <= duty_pend_next;
            if (load) begin
                per_act  <= per_pend;
                mode_act <= mode_pend;
                duty_act <= duty_pend_next;
            end
        end
    end

    always_comb begin
        pwm_next = '0;
        for (int c = 0; c < CH; c++) begin
            pwm_next[c] = enable & (cnt < duty_act[c]);
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= pwm_next;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_duty_q
        assign duty_q[c*W +: W] = duty_act[c];
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Randomised and directed stimulus for pwm_multi against a period-position reference model.
module tb_pwm_multi;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int EW  = CH + 1 + CH * W;
    localparam int MAXV = (1 << W) - 1;

    logic            clkin;
    logic            reset;
    logic            enable;
    logic            mode_in;
    logic            per_we;
    logic [W-1:0]    period_data;
    logic [1:0]      duty_op;
    logic [1:0]      duty_ch;
    logic [W-1:0]    duty_data;
    logic [CH-1:0]   pwm_out;
    logic            period_tick;
    logic [CH*W-1:0] duty_q;

    logic [EW-1:0] exp_q[$];
    int n_vec;
    int n_bad;

    // reference model state: position within the current period instead of cnt/phase
    int m_per_pend, m_per_act;
    int m_mode_pend, m_mode_act;
    int m_dp[CH];
    int m_da[CH];
    int m_t;

    pwm_multi #(.CH(CH), .W(W), .PERIOD_DEF(50)) dut (
        .clkin       (clkin),
        .reset       (reset),
        .enable      (enable),
        .mode_in     (mode_in),
        .per_we      (per_we),
        .period_data (period_data),
        .duty_op     (duty_op),
        .duty_ch     (duty_ch),
        .duty_data   (duty_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .duty_q      (duty_q)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic model_step();
        int np;
        int nd[CH];
        int len, pos, v;
        logic [CH-1:0]   e_pwm;
        logic            e_tick;
        logic [CH*W-1:0] e_dq;
        e_pwm  = '0;
        e_tick = 1'b0;
        if (reset) begin
            m_per_pend = 50; m_per_act = 50;
            m_mode_pend = 0; m_mode_act = 0;
            m_t = 0;
            for (int c = 0; c < CH; c++) begin m_dp[c] = 0; m_da[c] = 0; end
        end else begin
            np = per_we ? ((int'(period_data) < 2) ? 1 : int'(period_data)) : m_per_pend;
            nd = m_dp;
            v  = nd[duty_ch];
            case (duty_op)
                2'd1: v = int'(duty_data);
                2'd2: v = (v + int'(duty_data) > MAXV) ? MAXV : v + int'(duty_data);
                2'd3: v = (v - int'(duty_data) < 0) ? 0 : v - int'(duty_data);
                default: ;
            endcase
            nd[duty_ch] = v;
            if (!enable) begin
                m_t = 0;
                m_per_act = m_per_pend; m_mode_act = m_mode_pend; m_da = nd;
            end else begin
                len = (m_mode_act != 0) ? 2 * m_per_act : m_per_act;
                pos = (m_mode_act != 0 && m_t >= m_per_act) ? len - 1 - m_t : m_t;
                for (int c = 0; c < CH; c++) e_pwm[c] = (pos < m_da[c]);
                e_tick = (m_t == len - 1);
                if (e_tick) begin
                    m_t = 0;
                    m_per_act = m_per_pend; m_mode_act = m_mode_pend; m_da = nd;
                end else begin
                    m_t = m_t + 1;
                end
            end
            m_per_pend = np;
            m_mode_pend = int'(mode_in);
            m_dp = nd;
        end
        for (int c = 0; c < CH; c++) e_dq[c*W +: W] = W'(m_da[c]);
        exp_q.push_back({e_pwm, e_tick, e_dq});
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // monitor: every clock is an output beat, so pop one expectation per falling edge
    always @(negedge clkin) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pwm_out", 64'(pwm_out), 64'(e[EW-1 -: CH]));
            check("period_tick", 64'(period_tick), 64'(e[CH*W]));
            check("duty_q", 64'(duty_q), 64'(e[CH*W-1:0]));
        end
    end

    task automatic cycle();
        @(posedge clkin);
        model_step();
        #1;
        reset   = 1'b0;
        per_we  = 1'b0;
        duty_op = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr_per(input int p);
        per_we = 1'b1;
        period_data = W'(p);
        cycle();
    endtask

    task automatic do_op(input int o, input int ch, input int d);
        duty_op = 2'(o);
        duty_ch = 2'(ch);
        duty_data = W'(d);
        cycle();
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        reset = 1'b1; enable = 1'b1; mode_in = 1'b0; per_we = 1'b0;
        period_data = '0; duty_op = 2'd0; duty_ch = '0; duty_data = '0;
        repeat (3) begin reset = 1'b1; cycle(); end

        // default period 50, all duties zero
        idle(110);

        // program while disabled, then run edge mode
        enable = 1'b0;
        wr_per(10);
        do_op(1, 0, 3);
        idle(2);
        enable = 1'b1;
        idle(24);

        // mid-period duty change on ch1
        idle(4);
        do_op(1, 1, 7);
        idle(25);

        // center mode
        mode_in = 1'b1;
        idle(45);

        // saturation and period coercion
        do_op(1, 2, 250);
        do_op(2, 2, 10);
        idle(25);
        do_op(3, 2, 255);
        wr_per(0);
        do_op(1, 3, 1);
        idle(30);
        mode_in = 1'b0;
        wr_per(1);
        idle(30);
        wr_per(6);
        idle(20);

        // reset wins over simultaneous writes
        reset = 1'b1; per_we = 1'b1; period_data = 8'd20;
        duty_op = 2'd1; duty_ch = 2'd0; duty_data = 8'd99;
        cycle();
        idle(60);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if (enable) begin
                if ($urandom_range(0, 59) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) mode_in = ~mode_in;
            if ($urandom_range(0, 15) == 0) begin
                per_we = 1'b1;
                period_data = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 40))
                                                          : W'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 3) == 0) begin
                duty_op = 2'($urandom_range(1, 3));
                duty_ch = 2'($urandom_range(0, CH - 1));
                duty_data = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                        : W'($urandom_range(0, 14));
            end
            cycle();
        end

        idle(2);
        @(negedge clkin);
        @(negedge clkin);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
